// File: rtl/slm_seq_pkg.sv
// Shared types and constants for the UART-to-SPI command sequencer: command bytes,
// Bluejay register constants, FSM/parser state enums and the queued transaction type.
package slm_seq_pkg;

  localparam logic [7:0] CMD_RESET  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_WHOAMI = 8'h64;  // 'd'
  localparam logic [7:0] CMD_SETCLK = 8'h73;  // 's'
  localparam logic [7:0] CMD_RDCLK  = 8'h61;  // 'a'
  localparam logic [7:0] CMD_RAW    = 8'h77;  // 'w'

  localparam logic [7:0] SPI_ADDR_WHOAMI = 8'hF8;
  localparam logic [7:0] SPI_ADDR_SETCLK = 8'h09;
  localparam logic [7:0] SPI_DATA_SETCLK = 8'h32;
  localparam logic [7:0] SPI_ADDR_RDCLK  = 8'h89;
  localparam logic [7:0] SPI_DATA_ZERO   = 8'h00;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPLY} seq_state_t;
  typedef enum logic [1:0] {P_CMD, P_ADDR, P_DATA} parse_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } spi_txn_t;

  function automatic logic is_fixed_cmd(input logic [7:0] b);
    return (b == CMD_WHOAMI) || (b == CMD_SETCLK) || (b == CMD_RDCLK);
  endfunction

  function automatic spi_txn_t fixed_txn(input logic [7:0] b);
    spi_txn_t t;
    t.addr = SPI_ADDR_WHOAMI;
    t.data = SPI_DATA_ZERO;
    case (b)
      CMD_SETCLK: begin
        t.addr = SPI_ADDR_SETCLK;
        t.data = SPI_DATA_SETCLK;
      end
      CMD_RDCLK: t.addr = SPI_ADDR_RDCLK;
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/slm_cmd_fifo.sv
// Small synchronous FIFO of SPI transactions with flush; head entry is visible on o_dout
// whenever the FIFO is not empty.
module slm_cmd_fifo
  import slm_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  spi_txn_t                 i_din,
  input  logic                     i_pop,
  output spi_txn_t                 o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  spi_txn_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_wr_en;
  logic            w_rd_en;

  assign w_rd_en = i_pop && (r_count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en = i_push && ((r_count != FULL_CNT) || w_rd_en);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_wr_en && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/slm_spi_sequencer.sv
// UART command decoder + SPI transaction sequencer for the Bluejay SLM.
// Define SLM_SEQ_RAW_CMD_EN to enable the 'w' <addr> <data> raw-write parser.
module slm_spi_sequencer
  import slm_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_spi_start,
  output logic [7:0] o_spi_addr,
  output logic [7:0] o_spi_data,
  input  logic       i_spi_busy,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  output logic       o_soft_reset,
  output logic       o_overflow,
  output logic       o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam int FAW = $clog2(FIFO_DEPTH);

  seq_state_t      r_state;
  seq_state_t      w_state_next;
  spi_txn_t        r_txn;
  logic [7:0]      r_rx_byte;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic            r_soft_reset;
  logic            r_overflow;
  logic            r_timeout;

  logic            w_push;
  spi_txn_t        w_push_txn;
  logic            w_soft_rst;
  logic            w_pop;
  logic            w_start;
  logic            w_tx_dv;
  logic            w_timeout_hit;
  logic            w_rx_latch;
  logic            w_overflow_drop;
  logic            w_has_entry;

  spi_txn_t        w_fifo_dout;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [FAW:0]    w_fifo_count;

`ifdef SLM_SEQ_RAW_CMD_EN
  parse_state_t    r_parse;
  parse_state_t    w_parse_next;
  logic [7:0]      r_raw_addr;
`endif

  // Command decode feeds the FIFO directly, so the entry lands on the edge after i_rx_dv.
  always_comb begin
    w_push     = 1'b0;
    w_push_txn = '0;
    w_soft_rst = 1'b0;
`ifdef SLM_SEQ_RAW_CMD_EN
    w_parse_next = r_parse;
    if (i_rx_dv) begin
      case (r_parse)
        P_ADDR: w_parse_next = P_DATA;
        P_DATA: begin
          w_push          = 1'b1;
          w_push_txn.addr = r_raw_addr;
          w_push_txn.data = i_rx_byte;
          w_parse_next    = P_CMD;
        end
        default: begin
          if (i_rx_byte == CMD_RAW) begin
            w_parse_next = P_ADDR;
          end else if (is_fixed_cmd(i_rx_byte)) begin
            w_push     = 1'b1;
            w_push_txn = fixed_txn(i_rx_byte);
          end else if (i_rx_byte == CMD_RESET) begin
            w_soft_rst = 1'b1;
          end
        end
      endcase
    end
`else
    if (i_rx_dv) begin
      if (is_fixed_cmd(i_rx_byte)) begin
        w_push     = 1'b1;
        w_push_txn = fixed_txn(i_rx_byte);
      end else if (i_rx_byte == CMD_RESET) begin
        w_soft_rst = 1'b1;
      end
    end
`endif
  end

`ifdef SLM_SEQ_RAW_CMD_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_parse    <= P_CMD;
      r_raw_addr <= '0;
    end else begin
      r_parse <= w_parse_next;
      if (i_rx_dv && (r_parse == P_ADDR)) r_raw_addr <= i_rx_byte;
    end
  end
`endif

  slm_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (w_soft_rst),
    .i_push  (w_push),
    .i_din   (w_push_txn),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_has_entry     = !w_fifo_empty && (w_fifo_count != '0);
  assign w_overflow_drop = w_push && w_fifo_full && !w_pop;
  assign w_cnt_inc       = r_wait_cnt + 1'b1;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_pop         = 1'b0;
    w_start       = 1'b0;
    w_tx_dv       = 1'b0;
    w_timeout_hit = 1'b0;
    w_rx_latch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_has_entry && !i_spi_busy) begin
          w_pop        = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_spi_done) begin
          if (r_txn.addr[7]) begin
            w_rx_latch   = 1'b1;
            w_state_next = S_REPLY;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_cnt_inc == TIMEOUT_VAL) begin
          w_timeout_hit = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      S_REPLY: begin
        if (!i_tx_active) begin
          w_tx_dv      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Soft reset abandons whatever is in flight, including a pending reply.
    if (w_soft_rst) begin
      w_state_next  = S_IDLE;
      w_pop         = 1'b0;
      w_rx_latch    = 1'b0;
      w_timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_txn        <= '0;
      r_rx_byte    <= '0;
      r_wait_cnt   <= '0;
      r_soft_reset <= 1'b0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_soft_reset <= w_soft_rst;
      if (w_pop)      r_txn     <= w_fifo_dout;
      if (w_rx_latch) r_rx_byte <= i_spi_rx_byte;
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= w_cnt_inc;
      if (w_soft_rst) begin
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end else begin
        if (w_overflow_drop) r_overflow <= 1'b1;
        if (w_timeout_hit)   r_timeout  <= 1'b1;
      end
    end
  end

  assign o_spi_start  = w_start;
  assign o_spi_addr   = r_txn.addr;
  assign o_spi_data   = r_txn.data;
  assign o_tx_dv      = w_tx_dv;
  assign o_tx_byte    = r_rx_byte;
  assign o_soft_reset = r_soft_reset;
  assign o_overflow   = r_overflow;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_slm_spi_sequencer.sv
// Self-checking bench for slm_spi_sequencer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_slm_spi_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 50;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx_dv = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic       i_spi_busy = 1'b0;
  logic       i_spi_done = 1'b0;
  logic [7:0] i_spi_rx_byte = 8'h00;
  logic       i_tx_active = 1'b0;
  logic       o_spi_start;
  logic [7:0] o_spi_addr;
  logic [7:0] o_spi_data;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       o_soft_reset;
  logic       o_overflow;
  logic       o_timeout;

  always #10 i_clock = ~i_clock;

  slm_spi_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_rx_dv       (i_rx_dv),
    .i_rx_byte     (i_rx_byte),
    .o_spi_start   (o_spi_start),
    .o_spi_addr    (o_spi_addr),
    .o_spi_data    (o_spi_data),
    .i_spi_busy    (i_spi_busy),
    .i_spi_done    (i_spi_done),
    .i_spi_rx_byte (i_spi_rx_byte),
    .o_tx_dv       (o_tx_dv),
    .o_tx_byte     (o_tx_byte),
    .i_tx_active   (i_tx_active),
    .o_soft_reset  (o_soft_reset),
    .o_overflow    (o_overflow),
    .o_timeout     (o_timeout)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_REPLY = 3;
  logic [15:0] m_q[$];
  int          m_phase  = M_IDLE;
  logic [15:0] m_cur    = 16'h0;
  int          m_waited = 0;
  logic [7:0]  m_rd     = 8'h0;
  bit          m_ovf = 0, m_to = 0, m_srst = 0;
  int          m_pstate = 0;
  logic [7:0]  m_paddr  = 8'h0;
  bit          chk_en   = 0;

  always @(posedge i_clock) begin : model
    bit          push, srst, pop, full;
    logic [15:0] ptx;
    if (i_reset) begin
      m_q.delete();
      m_phase = M_IDLE; m_cur = 16'h0; m_rd = 8'h0;
      m_ovf = 0; m_to = 0; m_srst = 0; m_pstate = 0;
    end else begin
      push = 0; srst = 0; ptx = 16'h0;
      if (i_rx_dv) begin
`ifdef SLM_SEQ_RAW_CMD_EN
        if (m_pstate == 1) begin
          m_paddr = i_rx_byte; m_pstate = 2;
        end else if (m_pstate == 2) begin
          push = 1; ptx = {m_paddr, i_rx_byte}; m_pstate = 0;
        end else if (i_rx_byte == 8'h77) begin
          m_pstate = 1;
        end else
`endif
        case (i_rx_byte)
          8'h64: begin push = 1; ptx = 16'hF800; end
          8'h73: begin push = 1; ptx = 16'h0932; end
          8'h61: begin push = 1; ptx = 16'h8900; end
          8'h72: srst = 1;
          default: ;
        endcase
      end
      m_srst = srst;
      if (srst) begin
        m_q.delete();
        m_phase = M_IDLE; m_ovf = 0; m_to = 0;
      end else begin
        full = (m_q.size() == DEPTH);
        pop  = (m_phase == M_IDLE) && (m_q.size() > 0) && !i_spi_busy;
        case (m_phase)
          M_IDLE:  if (pop) begin m_cur = m_q.pop_front(); m_phase = M_ISSUE; end
          M_ISSUE: begin m_phase = M_WAIT; m_waited = 0; end
          M_WAIT: begin
            if (i_spi_done) begin
              if (m_cur[15]) begin m_rd = i_spi_rx_byte; m_phase = M_REPLY; end
              else m_phase = M_IDLE;
            end else begin
              m_waited++;
              if (m_waited == TMO) begin m_to = 1; m_phase = M_IDLE; end
            end
          end
          default: if (!i_tx_active) m_phase = M_IDLE;
        endcase
        if (push) begin
          if (!full || pop) m_q.push_back(ptx);
          else m_ovf = 1;
        end
      end
    end
  end

  always @(negedge i_clock) begin : compare
    bit exp_dv;
    if (!i_reset && chk_en) begin
      exp_dv = (m_phase == M_REPLY) && !i_tx_active;
      check("spi_start", o_spi_start, m_phase == M_ISSUE);
      check("spi_addr", o_spi_addr, m_cur[15:8]);
      check("spi_data", o_spi_data, m_cur[7:0]);
      check("tx_dv", o_tx_dv, exp_dv);
      if (exp_dv) check("tx_byte", o_tx_byte, m_rd);
      check("soft_reset", o_soft_reset, m_srst);
      check("overflow", o_overflow, m_ovf);
      check("timeout", o_timeout, m_to);
    end
  end

  // ---------------- stimulus ----------------
  bit         auto_resp = 0, rand_mode = 0, force_done = 0, rand_rx = 0;
  bit         busy_cmd = 0, txact_cmd = 0;
  int         resp_delay = 2, done_cd = 0;
  logic [7:0] resp_rx = 8'h00;
  int         n_start = 0, n_txdv = 0;
  logic [7:0] last_addr = 0, last_data = 0, last_tx_byte = 0;
  bit         obs_start, obs_srst, obs_ovf, obs_to;

  // One clock cycle: drive inputs just after the edge, observe at the falling edge.
  task automatic step(input bit dv, input logic [7:0] b);
    #1;
    i_rx_dv = dv;
    i_rx_byte = b;
    i_spi_done = 1'b0;
    if (force_done) begin
      i_spi_done = 1'b1; i_spi_rx_byte = resp_rx; force_done = 0;
    end else if (auto_resp && done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin
        i_spi_done = 1'b1;
        i_spi_rx_byte = rand_rx ? 8'($urandom_range(0, 255)) : resp_rx;
      end
    end
    if (rand_mode) begin
      i_spi_busy  = ($urandom_range(0, 3) == 0);
      i_tx_active = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 40) == 0) begin
        i_spi_done = 1'b1; i_spi_rx_byte = 8'($urandom_range(0, 255));
      end
    end else begin
      i_spi_busy  = busy_cmd;
      i_tx_active = txact_cmd;
    end
    @(negedge i_clock);
    obs_start = o_spi_start; obs_srst = o_soft_reset;
    obs_ovf = o_overflow; obs_to = o_timeout;
    if (o_spi_start) begin
      n_start++; last_addr = o_spi_addr; last_data = o_spi_data;
      done_cd = rand_mode ? $urandom_range(0, 8) : resp_delay;
    end
    if (o_tx_dv) begin
      n_txdv++; last_tx_byte = o_tx_byte;
    end
    @(posedge i_clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t0, r;
    bit dv;
    logic [7:0] b;
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_start", o_spi_start, 0);
    check("rst_addr", o_spi_addr, 0);
    check("rst_txdv", o_tx_dv, 0);
    check("rst_srst", o_soft_reset, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_to", o_timeout, 0);
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    @(posedge i_clock);
    chk_en = 1;

    // 'd': start at +2 cycles, read reply 5A
    auto_resp = 1; rand_rx = 0; resp_rx = 8'h5A; resp_delay = 2;
    t0 = n_txdv;
    step(1, 8'h64);
    step(0, 8'h00); check("d_lat_c1", obs_start, 0);
    step(0, 8'h00); check("d_lat_c2", obs_start, 1);
    check("d_addr", last_addr, 8'hF8);
    check("d_data", last_data, 8'h00);
    repeat (8) step(0, 8'h00);
    check("d_reply_cnt", n_txdv - t0, 1);
    check("d_reply_byte", last_tx_byte, 8'h5A);

    // 's': write, no reply; FSM idle again so the next 'd' has the same latency
    s0 = n_start; t0 = n_txdv;
    step(1, 8'h73);
    repeat (6) step(0, 8'h00);
    check("s_start_cnt", n_start - s0, 1);
    check("s_addr", last_addr, 8'h09);
    check("s_data", last_data, 8'h32);
    check("s_no_reply", n_txdv - t0, 0);
    step(1, 8'h64); step(0, 8'h00); step(0, 8'h00);
    check("s_then_d_lat", obs_start, 1);
    repeat (8) step(0, 8'h00);

    // 5 x 'a' while busy -> overflow; then 4 transactions and 4 replies
    busy_cmd = 1; s0 = n_start; t0 = n_txdv;
    repeat (4) step(1, 8'h61);
    step(1, 8'h61); check("ovf_after4", obs_ovf, 0);
    step(0, 8'h00); check("ovf_after5", obs_ovf, 1);
    busy_cmd = 0; rand_rx = 1;
    repeat (40) step(0, 8'h00);
    check("ovf_starts", n_start - s0, 4);
    check("ovf_replies", n_txdv - t0, 4);

    // timeout: done withheld
    auto_resp = 0; s0 = n_start; t0 = n_txdv;
    step(1, 8'h64);
    repeat (TMO + 8) step(0, 8'h00);
    check("to_flag", obs_to, 1);
    check("to_start_cnt", n_start - s0, 1);
    check("to_no_reply", n_txdv - t0, 0);
    auto_resp = 1; rand_rx = 0; resp_rx = 8'hA7;
    step(1, 8'h61);
    repeat (12) step(0, 8'h00);
    check("to_next_addr", last_addr, 8'h89);
    check("to_next_reply", n_txdv - t0, 1);
    check("to_next_byte", last_tx_byte, 8'hA7);

    // soft reset while in WAIT
    auto_resp = 0; t0 = n_txdv;
    step(1, 8'h61);
    repeat (4) step(0, 8'h00);
    step(1, 8'h72); check("sr_pre", obs_srst, 0);
    step(0, 8'h00);
    check("sr_pulse", obs_srst, 1);
    check("sr_ovf_clr", obs_ovf, 0);
    check("sr_to_clr", obs_to, 0);
    step(0, 8'h00); check("sr_one_cycle", obs_srst, 0);
    resp_rx = 8'h33; force_done = 1; s0 = n_start;
    repeat (10) step(0, 8'h00);
    check("sr_no_reply", n_txdv - t0, 0);
    check("sr_fifo_empty", n_start - s0, 0);

    // raw write command
    auto_resp = 1; rand_rx = 0; resp_rx = 8'hC3; s0 = n_start; t0 = n_txdv;
    step(1, 8'h77); step(1, 8'h8A); step(1, 8'h00);
    repeat (12) step(0, 8'h00);
`ifdef SLM_SEQ_RAW_CMD_EN
    check("raw_start_cnt", n_start - s0, 1);
    check("raw_addr", last_addr, 8'h8A);
    check("raw_data", last_data, 8'h00);
    check("raw_reply", n_txdv - t0, 1);
    check("raw_byte", last_tx_byte, 8'hC3);
`else
    check("raw_ignored_start", n_start - s0, 0);
    check("raw_ignored_reply", n_txdv - t0, 0);
`endif

    // randomized traffic against the model
    rand_mode = 1; rand_rx = 1;
    for (int i = 0; i < 3000; i++) begin
      dv = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 19);
      if (r < 4)       b = 8'h64;
      else if (r < 8)  b = 8'h73;
      else if (r < 13) b = 8'h61;
      else if (r == 18) b = 8'h77;
      else if (r == 19) b = 8'h72;
      else             b = 8'($urandom_range(0, 255));
      step(dv, b);
    end
    rand_mode = 0; busy_cmd = 0; txact_cmd = 0;
    repeat (20) step(0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
